donut_raygen: RTL and testbench
===============================

# donut_raygen

Ray-issuing initiator that feeds the donut ray-march hit unit and consumes its results. The block walks one scanline of rays at a time, stepping a 3-vector direction per column and per row, and pulses `start_o` with origin, ray and light vectors. It samples `hit_i`/`light_i` after the march latency, quantizes the result to a 6-bit shade, and emits it on a valid/ready pixel stream toward the VGA line buffer.

## Interface
- `MARCH_STEPS`, default 8: clocks from `start_o` to result sampling.
- `RAYS_PER_LINE`, default 80: rays per scanline.
- `BG_SHADE`, default 0: shade emitted on a miss.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_start` in 1: pulse; latch the base and step vectors, reset the row state.
- `line_go` in 1: pulse; march one scanline.
- `org_x/y/z` in 16 signed: camera origin, frame-constant.
- `lgt_x/y/z` in 16 signed: light direction, 2.14 format.
- `dir0_x/y/z` in 16 signed: top-left ray direction, 2.14 format.
- `colstep_x/y/z`, `rowstep_x/y/z` in 16 signed: per-column and per-row direction increments.
- `start_o` out 1: one-cycle start to the hit unit.
- `p*_o`, `r*_o`, `l*_o` out 16 signed each: origin, ray and light, valid while `start_o`=1.
- `hit_i` in 1, `light_i` in 16 signed: hit-unit results.
- `pix_valid` out 1, `pix_ready` in 1, `pix_shade` out 6, `pix_hit` out 1: pixel stream.
- `line_done` out 1: one-cycle pulse after the last pixel of a line is accepted.

## Operation
- The FSM has four states: IDLE, ISSUE, MARCH, EMIT.
- IDLE:
  - `line_go` moves to ISSUE.
  - `col` is set to 0.
  - `ray` is loaded from `row_dir`.
- ISSUE:
  - `start_o`=1 for exactly one cycle.
  - The outputs drive `org`, `ray` and `lgt_latched`.
  - The FSM moves to MARCH with `cnt`=1.
- MARCH:
  - `cnt` increments every clock.
  - When `cnt`==`MARCH_STEPS`, the block captures `hit_i` and `light_i`, computes the shade, and moves to EMIT.
- EMIT:
  - `pix_valid`=1. Data is held stable until `pix_ready`.
  - On accept, if `col`<`RAYS_PER_LINE`-1: `ray` += `colstep`, `col`++, go to ISSUE.
  - On accept of the last column: `row_dir` += `rowstep`, pulse `line_done`, go to IDLE.
- Vector arithmetic is 16-bit two's complement per component and wraps silently; there is no saturation.
- Shade:
  - A miss gives `BG_SHADE`.
  - A hit with `light_i`<=0 gives 0.
  - A hit with `light_i`>=16384 gives 63.
  - Any other hit gives `light_i[13:8]`.
- `frame_start`:
  - Latches `lgt`, `colstep` and `rowstep`, and sets `row_dir` to `dir0`.
  - In any state other than IDLE it aborts: the FSM goes to IDLE, the in-flight ray is dropped, and no `pix_valid` or `line_done` is produced for it.
- `frame_start` and `line_go` in the same cycle: the frame load wins, then the line starts next cycle from the fresh `dir0`.
- `line_go` outside IDLE is ignored.

## Timing
- Reset values:
  - `start_o`, `pix_valid`, `line_done`, `pix_hit`, `pix_shade` = 0.
  - State = IDLE; `col`, `cnt` = 0.
  - `ray`, `row_dir`, steps and latched light = 0.
- Reset mid-line drops all state; `start_o` is 0 on the first cycle after reset.
- `line_go` at cycle L gives `start_o` at L+1.
- `start_o` at cycle S gives the sample at S+`MARCH_STEPS` and `pix_valid` at S+`MARCH_STEPS`+1.
- With `pix_ready` held high, one pixel completes every `MARCH_STEPS`+2 cycles. A line takes `RAYS_PER_LINE`·(`MARCH_STEPS`+2) cycles.
- Backpressure stalls only EMIT. The hit unit is never restarted while a ray is pending.
- `line_done` asserts in the cycle after the final accept.

## Configuration
- `DONUT_RAYGEN_DITHER_EN` defined:
  - The hit shade adds 1 (saturating at 63) when `light_i[7:4]` > `bayer4x4[row[1:0]][col[1:0]]`.
  - `row` is a 2-bit line counter cleared by `frame_start`.
  - Miss shading is unchanged.
- `DONUT_RAYGEN_DITHER_EN` undefined: plain truncation; the row counter is not instantiated.

## Structure
- Shared package `donut_pkg`:
  - the `vec3_t` 3×16 signed struct
  - the state enum
  - shade width 6
  - the 2.14 unit constant 16384
  - the 4×4 Bayer table
- Sub-module `donut_shade`: combinational quantizer (hit, light, col, row → shade), holding the dither logic.
- The hit unit is instantiated by the parent, not inside this block.

## Test plan
- Line throughput:
  - Stimulus: reset, then `frame_start` with `dir0`=(0,0,16384), `colstep`=(64,0,0); `line_go`; `pix_ready`=1; stub returns hit=1, light=8192.
  - Required: 80 pixels with shade 32, `start_o` spaced 10 cycles apart, `line_done` once.
  - Required: the 3rd `start_o` carries `r_x`=128.
- Start latency: a stub records `start_o` at S → the sample is taken at S+8 and `pix_valid` rises at S+9.
- Backpressure:
  - Stimulus: `pix_ready` low for 5 cycles on pixel 2.
  - Required: shade/hit stable throughout, no new `start_o` before the accept, and totals unchanged.
- Shade clamps:
  - light=-5 gives 0; light=20000 gives 63; light=256 gives 1.
  - A miss gives `BG_SHADE`.
- Abort:
  - Stimulus: `frame_start` during MARCH of column 5.
  - Required: no `pix_valid` for that ray, and the next `line_go` restarts at `col` 0 with `row_dir`=`dir0`.
- Reset mid-line:
  - Stimulus: `rst_n` low for 1 cycle in EMIT.
  - Required: `pix_valid`=0 next cycle, and all outputs match the reset values.
- Wrap: `dir0_x`=32704, `colstep_x`=128 → column 1 `r_x`=-32704.

Source files
------------

// File: rtl/donut_pkg.sv
// Shared types and constants for the donut ray generator.
package donut_pkg;

  // Vector component and shade widths.
  localparam int COMP_W  = 16;
  localparam int SHADE_W = 6;

  localparam logic [SHADE_W-1:0] SHADE_MAX = '1;

  // 1.0 in 2.14 fixed point.
  localparam logic signed [COMP_W-1:0] UNIT_2P14 = 16'sd16384;

  // 4x4 ordered-dither thresholds, indexed [row][col].
  localparam logic [0:3][0:3][3:0] BAYER4X4 = 64'h082A_C4E6_3B19_F7D5;

  typedef struct packed {
    logic signed [COMP_W-1:0] x;
    logic signed [COMP_W-1:0] y;
    logic signed [COMP_W-1:0] z;
  } vec3_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_MARCH = 2'd2,
    ST_EMIT  = 2'd3
  } raygen_state_e;

  // Component-wise add; each component wraps at 16 bits.
  function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
    vec3_t s;
    s.x = a.x + b.x;
    s.y = a.y + b.y;
    s.z = a.z + b.z;
    return s;
  endfunction

endpackage

// File: rtl/donut_shade.sv
// Combinational quantizer: hit flag and 2.14 light value to a 6-bit shade.
// Optional ordered dither is enabled by defining DONUT_RAYGEN_DITHER_EN.
module donut_shade
  import donut_pkg::*;
#(
  parameter logic [SHADE_W-1:0] BG_SHADE = '0
) (
  input  logic                      hit,
  input  logic signed [COMP_W-1:0]  light,
`ifdef DONUT_RAYGEN_DITHER_EN
  input  logic [1:0]                col,
  input  logic [1:0]                row,
`endif
  output logic [SHADE_W-1:0]        shade
);

  // Clamp out-of-range light, otherwise take the top six fraction bits.
  always_comb begin
    shade = BG_SHADE;
    if (hit) begin
      if (light <= 16'sd0) begin
        shade = '0;
      end else if (light >= UNIT_2P14) begin
        shade = SHADE_MAX;
      end else begin
        shade = light[13:8];
`ifdef DONUT_RAYGEN_DITHER_EN
        if ((light[7:4] > BAYER4X4[row][col]) && (shade != SHADE_MAX)) begin
          shade = shade + SHADE_W'(1);
        end
`endif
      end
    end
  end

endmodule

// File: rtl/donut_raygen.sv
// Scanline ray issuer for the donut ray-march hit unit.
// Walks one line of rays per line_go, issues each to the hit unit, samples
// the result MARCH_STEPS clocks later and streams a quantized shade out.
// Define DONUT_RAYGEN_DITHER_EN to add ordered dithering (adds a row counter).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for line_go; col held at 0
// ISSUE | start_o high for one cycle with origin, ray and light
// MARCH | counting hit-unit latency; result captured at cnt==MARCH_STEPS
// EMIT  | pix_valid high, held until pix_ready; then next column or done
module donut_raygen
  import donut_pkg::*;
#(
  parameter int                 MARCH_STEPS   = 8,
  parameter int                 RAYS_PER_LINE = 80,
  parameter logic [SHADE_W-1:0] BG_SHADE      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     line_go,
  input  logic signed [COMP_W-1:0] org_x,
  input  logic signed [COMP_W-1:0] org_y,
  input  logic signed [COMP_W-1:0] org_z,
  input  logic signed [COMP_W-1:0] lgt_x,
  input  logic signed [COMP_W-1:0] lgt_y,
  input  logic signed [COMP_W-1:0] lgt_z,
  input  logic signed [COMP_W-1:0] dir0_x,
  input  logic signed [COMP_W-1:0] dir0_y,
  input  logic signed [COMP_W-1:0] dir0_z,
  input  logic signed [COMP_W-1:0] colstep_x,
  input  logic signed [COMP_W-1:0] colstep_y,
  input  logic signed [COMP_W-1:0] colstep_z,
  input  logic signed [COMP_W-1:0] rowstep_x,
  input  logic signed [COMP_W-1:0] rowstep_y,
  input  logic signed [COMP_W-1:0] rowstep_z,
  output logic                     start_o,
  output logic signed [COMP_W-1:0] p_x_o,
  output logic signed [COMP_W-1:0] p_y_o,
  output logic signed [COMP_W-1:0] p_z_o,
  output logic signed [COMP_W-1:0] r_x_o,
  output logic signed [COMP_W-1:0] r_y_o,
  output logic signed [COMP_W-1:0] r_z_o,
  output logic signed [COMP_W-1:0] l_x_o,
  output logic signed [COMP_W-1:0] l_y_o,
  output logic signed [COMP_W-1:0] l_z_o,
  input  logic                     hit_i,
  input  logic signed [COMP_W-1:0] light_i,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [SHADE_W-1:0]       pix_shade,
  output logic                     pix_hit,
  output logic                     line_done
);

  localparam int CNT_W = $clog2(MARCH_STEPS + 1);
  localparam int COL_W = (RAYS_PER_LINE > 1) ? $clog2(RAYS_PER_LINE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MARCH_STEPS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(RAYS_PER_LINE - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_MARCH = ST_MARCH;
  localparam logic [1:0] S_EMIT  = ST_EMIT;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [COL_W-1:0]   col;
  vec3_t              ray;
  vec3_t              row_dir;
  vec3_t              col_step;
  vec3_t              row_step;
  vec3_t              lgt;
  logic               go_pend;
  logic [SHADE_W-1:0] shade;
`ifdef DONUT_RAYGEN_DITHER_EN
  logic [1:0]         row;
`endif

  vec3_t dir0_in;
  vec3_t colstep_in;
  vec3_t rowstep_in;
  vec3_t lgt_in;

  assign dir0_in    = '{x: dir0_x,    y: dir0_y,    z: dir0_z};
  assign colstep_in = '{x: colstep_x, y: colstep_y, z: colstep_z};
  assign rowstep_in = '{x: rowstep_x, y: rowstep_y, z: rowstep_z};
  assign lgt_in     = '{x: lgt_x,     y: lgt_y,     z: lgt_z};

  // Hit-unit request: origin is frame-constant and passed straight through.
  assign start_o = (state == S_ISSUE);
  assign p_x_o   = org_x;
  assign p_y_o   = org_y;
  assign p_z_o   = org_z;
  assign r_x_o   = ray.x;
  assign r_y_o   = ray.y;
  assign r_z_o   = ray.z;
  assign l_x_o   = lgt.x;
  assign l_y_o   = lgt.y;
  assign l_z_o   = lgt.z;

  assign pix_valid = (state == S_EMIT);

  donut_shade #(
    .BG_SHADE (BG_SHADE)
  ) u_shade (
    .hit   (hit_i),
    .light (light_i),
`ifdef DONUT_RAYGEN_DITHER_EN
    .col   (col[1:0]),
    .row   (row),
`endif
    .shade (shade)
  );

  // Sequencer: frame load/abort has priority over all line activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      col       <= '0;
      ray       <= '0;
      row_dir   <= '0;
      col_step  <= '0;
      row_step  <= '0;
      lgt       <= '0;
      go_pend   <= 1'b0;
      pix_shade <= '0;
      pix_hit   <= 1'b0;
      line_done <= 1'b0;
`ifdef DONUT_RAYGEN_DITHER_EN
      row       <= '0;
`endif
    end else begin
      line_done <= 1'b0;
      if (frame_start) begin
        // A line_go arriving with the frame load is replayed next cycle so
        // it starts from the fresh dir0.
        lgt      <= lgt_in;
        col_step <= colstep_in;
        row_step <= rowstep_in;
        row_dir  <= dir0_in;
        state    <= S_IDLE;
        col      <= '0;
        cnt      <= '0;
        go_pend  <= line_go;
`ifdef DONUT_RAYGEN_DITHER_EN
        row      <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            col <= '0;
            if (line_go || go_pend) begin
              ray     <= row_dir;
              go_pend <= 1'b0;
              state   <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            cnt   <= CNT_W'(1);
            state <= S_MARCH;
          end
          S_MARCH: begin
            if (cnt == CNT_LAST) begin
              pix_shade <= shade;
              pix_hit   <= hit_i;
              cnt       <= '0;
              state     <= S_EMIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_EMIT: begin
            if (pix_ready) begin
              if (col != COL_LAST) begin
                ray   <= vec3_add(ray, col_step);
                col   <= col + COL_W'(1);
                state <= S_ISSUE;
              end else begin
                row_dir   <= vec3_add(row_dir, row_step);
                line_done <= 1'b1;
                state     <= S_IDLE;
`ifdef DONUT_RAYGEN_DITHER_EN
                row       <= row + 2'd1;
`endif
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_donut_raygen.sv
// Directed bench for donut_raygen (default build, dither disabled).
module tb_donut_raygen;

  localparam int MS   = 8;
  localparam int RAYS = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic line_go = 1'b0;
  logic pix_ready = 1'b1;
  logic hit_i = 1'b0;
  logic signed [15:0] light_i = 16'sh7fff;
  logic signed [15:0] org_x = 0, org_y = 0, org_z = 0;
  logic signed [15:0] lgt_x = 0, lgt_y = 0, lgt_z = 0;
  logic signed [15:0] dir0_x = 0, dir0_y = 0, dir0_z = 0;
  logic signed [15:0] colstep_x = 0, colstep_y = 0, colstep_z = 0;
  logic signed [15:0] rowstep_x = 0, rowstep_y = 0, rowstep_z = 0;

  logic start_o, pix_valid, pix_hit, line_done;
  logic [5:0] pix_shade;
  logic signed [15:0] p_x_o, p_y_o, p_z_o, r_x_o, r_y_o, r_z_o, l_x_o, l_y_o, l_z_o;

  donut_raygen dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_go(line_go),
    .org_x(org_x), .org_y(org_y), .org_z(org_z),
    .lgt_x(lgt_x), .lgt_y(lgt_y), .lgt_z(lgt_z),
    .dir0_x(dir0_x), .dir0_y(dir0_y), .dir0_z(dir0_z),
    .colstep_x(colstep_x), .colstep_y(colstep_y), .colstep_z(colstep_z),
    .rowstep_x(rowstep_x), .rowstep_y(rowstep_y), .rowstep_z(rowstep_z),
    .start_o(start_o),
    .p_x_o(p_x_o), .p_y_o(p_y_o), .p_z_o(p_z_o),
    .r_x_o(r_x_o), .r_y_o(r_y_o), .r_z_o(r_z_o),
    .l_x_o(l_x_o), .l_y_o(l_y_o), .l_z_o(l_z_o),
    .hit_i(hit_i), .light_i(light_i),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_shade(pix_shade), .pix_hit(pix_hit), .line_done(line_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Event log filled by the monitor, cleared by the stimulus between lines.
  int n_start = 0, n_acc = 0, n_done = 0, bad_lat = 0;
  int last_start = -1000, last_k = 0, last_acc = 0, done_cyc = 0;
  int start_cyc [RAYS];
  logic signed [15:0] start_rx [RAYS];
  logic signed [15:0] start_ry [RAYS];
  logic signed [15:0] start_rz [RAYS];
  logic signed [15:0] start_lx [RAYS];
  logic signed [15:0] start_px [RAYS];
  logic [5:0] shade_log [RAYS];
  logic       hit_log   [RAYS];
  logic       pv_prev = 1'b0;

  // Hit-unit stub answers: valid only in the sample cycle S+MS, garbage otherwise.
  logic               stub_hit   [RAYS];
  logic signed [15:0] stub_light [RAYS];

  always @(negedge clk) begin
    if (start_o) begin
      if (n_start < RAYS) begin
        start_cyc[n_start] = cyc;
        start_rx[n_start]  = r_x_o;
        start_ry[n_start]  = r_y_o;
        start_rz[n_start]  = r_z_o;
        start_lx[n_start]  = l_x_o;
        start_px[n_start]  = p_x_o;
      end
      last_k     = (n_start < RAYS) ? n_start : RAYS - 1;
      last_start = cyc;
      n_start++;
    end
    if (pix_valid && !pv_prev && (cyc != last_start + MS + 1)) bad_lat++;
    pv_prev = pix_valid;
    if (pix_valid && pix_ready) begin
      if (n_acc < RAYS) begin
        shade_log[n_acc] = pix_shade;
        hit_log[n_acc]   = pix_hit;
      end
      last_acc = cyc;
      n_acc++;
    end
    if (line_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (cyc == last_start + MS) begin
      hit_i   = stub_hit[last_k];
      light_i = stub_light[last_k];
    end else begin
      hit_i   = 1'b0;
      light_i = 16'sh7fff;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log;
    n_start = 0; n_acc = 0; n_done = 0; bad_lat = 0;
  endtask

  task automatic fill_stub(input logic h, input logic signed [15:0] l);
    for (int i = 0; i < RAYS; i++) begin
      stub_hit[i]   = h;
      stub_light[i] = l;
    end
  endtask

  int L, E, bad, hold_shade, acc_snap, noact;

  initial begin
    fill_stub(1'b1, 16'sd8192);
    repeat (3) tick;

    // Reset state
    chk("rst_start", start_o, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_pix_hit", pix_hit, 0);
    chk("rst_pix_shade", pix_shade, 0);
    chk("rst_r_x", r_x_o, 0);
    chk("rst_l_x", l_x_o, 0);
    rst_n = 1'b1;
    tick;

    // Line 1: throughput, latency, column stepping
    org_x = 1; org_y = 2; org_z = 3;
    lgt_x = 100; lgt_y = 200; lgt_z = 300;
    dir0_x = 0; dir0_y = 0; dir0_z = 16384;
    colstep_x = 64; colstep_y = 0; colstep_z = 0;
    rowstep_x = 0; rowstep_y = 32; rowstep_z = 0;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    clear_log;
    L = cyc;
    line_go = 1'b1; tick; line_go = 1'b0;
    for (int w = 0; w < 1200 && n_done == 0; w++) tick;
    repeat (3) tick;
    chk("l1_line_done", n_done, 1);
    chk("l1_starts", n_start, 80);
    chk("l1_pixels", n_acc, 80);
    chk("l1_first_start", start_cyc[0], L + 1);
    bad = 0;
    for (int i = 1; i < RAYS; i++) if (start_cyc[i] - start_cyc[i-1] != 10) bad++;
    chk("l1_spacing", bad, 0);
    bad = 0;
    for (int i = 0; i < RAYS; i++) if (shade_log[i] !== 6'd32 || hit_log[i] !== 1'b1) bad++;
    chk("l1_shades", bad, 0);
    chk("l1_r_x_3rd", start_rx[2], 128);
    chk("l1_r_z_1st", start_rz[0], 16384);
    chk("l1_l_x", start_lx[0], 100);
    chk("l1_p_x", start_px[0], 1);
    chk("l1_valid_latency", bad_lat, 0);
    chk("l1_done_after_accept", done_cyc - last_acc, 1);
    chk("l1_line_cycles", done_cyc - L, 80 * 10 + 1);

    // Line 2: shade clamps, miss, backpressure on pixel 2
    fill_stub(1'b1, 16'sd8192);
    stub_light[0] = -16'sd5;
    stub_light[1] = 16'sd20000;
    stub_light[2] = 16'sd256;
    stub_hit[3]   = 1'b0;
    stub_light[4] = 16'sd16384;
    stub_light[5] = 16'sd0;
    stub_light[6] = 16'sd16383;
    stub_light[7] = 16'sd255;
    clear_log;
    line_go = 1'b1; tick; line_go = 1'b0;
    for (int w = 0; w < 100 && n_start < 3; w++) tick;
    pix_ready = 1'b0;
    for (int w = 0; w < 30 && !pix_valid; w++) tick;
    E = cyc;
    acc_snap = n_acc;
    bad = 0;
    for (int i = 0; i <= 5; i++) begin
      if (pix_valid !== 1'b1 || pix_shade !== 6'd1 || pix_hit !== 1'b1 || start_o !== 1'b0) bad++;
      if (i == 5) pix_ready = 1'b1;
      tick;
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_accept", acc_snap, 2);
    chk("bp_restart", start_o, 1);
    chk("bp_restart_cycle", cyc, E + 6);
    for (int w = 0; w < 1200 && n_done == 0; w++) tick;
    repeat (3) tick;
    chk("l2_line_done", n_done, 1);
    chk("l2_pixels", n_acc, 80);
    chk("l2_starts", n_start, 80);
    chk("shade_neg", shade_log[0], 0);
    chk("shade_20000", shade_log[1], 63);
    chk("shade_256", shade_log[2], 1);
    chk("shade_miss", shade_log[3], 0);
    chk("hit_miss", hit_log[3], 0);
    chk("shade_unit", shade_log[4], 63);
    chk("shade_zero", shade_log[5], 0);
    chk("shade_16383", shade_log[6], 63);
    chk("shade_255", shade_log[7], 0);
    chk("shade_mid", shade_log[40], 32);
    chk("l2_row_y", start_ry[0], 32);
    chk("l2_last_x", start_rx[79], 5056);
    chk("l2_valid_latency", bad_lat, 0);

    // Line 3: abort during MARCH of column 5
    fill_stub(1'b1, 16'sd8192);
    clear_log;
    line_go = 1'b1; tick; line_go = 1'b0;
    for (int w = 0; w < 200 && n_start < 6; w++) tick;
    repeat (3) tick;
    dir0_x = 1000; dir0_y = 0; dir0_z = 0;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    noact = 0;
    for (int i = 0; i < 15; i++) begin
      if (pix_valid || line_done || start_o) noact++;
      tick;
    end
    chk("abort_quiet", noact, 0);
    chk("abort_pixels", n_acc, 5);
    chk("abort_no_done", n_done, 0);
    clear_log;
    L = cyc;
    line_go = 1'b1; tick; line_go = 1'b0;
    for (int w = 0; w < 40 && n_start < 2; w++) tick;
    chk("abort_restart_cycle", start_cyc[0], L + 1);
    chk("abort_col0_x", start_rx[0], 1000);
    chk("abort_col0_y", start_ry[0], 0);
    chk("abort_col1_x", start_rx[1], 1064);

    // Wrap: reload mid-line (abort) with a near-limit dir0
    dir0_x = 32704; colstep_x = 128;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    clear_log;
    line_go = 1'b1; tick; line_go = 1'b0;
    for (int w = 0; w < 40 && n_start < 2; w++) tick;
    chk("wrap_col0_x", start_rx[0], 32704);
    chk("wrap_col1_x", start_rx[1], -32704);

    // Reset for one cycle while in EMIT
    for (int w = 0; w < 30 && !pix_valid; w++) tick;
    chk("pre_reset_emit", pix_valid, 1);
    rst_n = 1'b0; tick; rst_n = 1'b1;
    chk("mid_rst_pix_valid", pix_valid, 0);
    chk("mid_rst_start", start_o, 0);
    chk("mid_rst_line_done", line_done, 0);
    chk("mid_rst_pix_hit", pix_hit, 0);
    chk("mid_rst_pix_shade", pix_shade, 0);
    chk("mid_rst_r_x", r_x_o, 0);
    chk("mid_rst_l_x", l_x_o, 0);
    clear_log;
    repeat (12) tick;
    chk("post_rst_idle", n_start + n_acc + n_done, 0);

    // frame_start and line_go together: line starts one cycle later from new dir0
    lgt_x = -7;
    dir0_x = 5; dir0_y = 6; dir0_z = 7;
    colstep_x = 1;
    clear_log;
    L = cyc;
    frame_start = 1'b1; line_go = 1'b1; tick;
    frame_start = 1'b0; line_go = 1'b0;
    for (int w = 0; w < 20 && n_start < 1; w++) tick;
    chk("both_start_cycle", start_cyc[0], L + 2);
    chk("both_r_x", start_rx[0], 5);
    chk("both_r_z", start_rz[0], 7);
    chk("both_l_x", start_lx[0], -7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
